// File: rtl/ex_operand_stage_pkg.sv
// ex_operand_stage_pkg: ALU op codes, forward-select codes and stage states shared by the operand stage.
package ex_operand_stage_pkg;
    localparam logic [3:0] ALU_ADD_OP  = 4'd0;
    localparam logic [3:0] ALU_SUB_OP  = 4'd1;
    localparam logic [3:0] ALU_AND_OP  = 4'd2;
    localparam logic [3:0] ALU_OR_OP   = 4'd3;
    localparam logic [3:0] ALU_XOR_OP  = 4'd4;
    localparam logic [3:0] ALU_SLL_OP  = 4'd5;
    localparam logic [3:0] ALU_SRL_OP  = 4'd6;
    localparam logic [3:0] ALU_SRA_OP  = 4'd7;
    localparam logic [3:0] ALU_SLT_OP  = 4'd8;
    localparam logic [3:0] ALU_SLTU_OP = 4'd9;
    typedef enum logic [1:0] {FWD_EX, FWD_MEM, FWD_WB, FWD_RF} fwd_sel_e;
    typedef enum logic [1:0] {ADVANCE, BUBBLE, HOLD} stage_st_e;
endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// fwd_mux: priority operand select EX > MEM > WB > register file; x0 always reads zero.
module fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs_i,
    input  logic            ex_en_i,
    input  logic [4:0]      ex_rd_i,
    input  logic [XLEN-1:0] ex_data_i,
    input  logic            mem_en_i,
    input  logic [4:0]      mem_rd_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic [XLEN-1:0] rf_data_i,
    output logic [XLEN-1:0] data_o
);
    fwd_sel_e sel;
    always_comb begin
        sel = (ex_en_i && ex_rd_i == rs_i)   ? FWD_EX  :
              (mem_en_i && mem_rd_i == rs_i) ? FWD_MEM :
              (wb_en_i && wb_rd_i == rs_i)   ? FWD_WB  : FWD_RF;
        data_o = (rs_i == 5'd0)  ? '0         :
                 (sel == FWD_EX)  ? ex_data_i  :
                 (sel == FWD_MEM) ? mem_data_i :
                 (sel == FWD_WB)  ? wb_data_i  : rf_data_i;
    end
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: EX pipeline register with operand forwarding and load-use/stall/flush handling.
// Define EX_FORWARD_EN to enable EX and MEM forwarding; otherwise those hazards stall until they clear.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic            in_use_imm,
    input  logic            in_use_pc,
    input  logic            in_reg_write,
    input  logic            in_mem_read,
    input  logic [3:0]      in_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_data,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_stall,
    input  logic            flush,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_op,
    output logic [4:0]      ex_rd
);
    logic            ex_valid_q, ex_reg_write_q, ex_mem_read_q;
    logic            ex_valid_d, ex_reg_write_d, ex_mem_read_d;
    logic [XLEN-1:0] ex_a_q, ex_b_q, ex_a_d, ex_b_d, rs1_val, rs2_val;
    logic [3:0]      ex_op_q, ex_op_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic            use1, use2, ex_hit, load_use, hazard, ex_fwd, mem_fwd;
    stage_st_e       st;

    assign use1     = !in_use_pc && in_rs1 != 5'd0;
    assign use2     = !in_use_imm && in_rs2 != 5'd0;
    assign ex_hit   = ex_rd_q != 5'd0 && ((use1 && in_rs1 == ex_rd_q) || (use2 && in_rs2 == ex_rd_q));
    assign load_use = ex_valid_q && ex_mem_read_q && ex_hit;
`ifdef EX_FORWARD_EN
    assign ex_fwd  = ex_valid_q && ex_reg_write_q && !ex_mem_read_q;
    assign mem_fwd = mem_reg_write;
    assign hazard  = load_use;
`else
    logic mem_hit;
    assign mem_hit = mem_rd != 5'd0 && ((use1 && in_rs1 == mem_rd) || (use2 && in_rs2 == mem_rd));
    assign ex_fwd  = 1'b0;
    assign mem_fwd = 1'b0;
    assign hazard  = load_use || (ex_valid_q && ex_reg_write_q && ex_hit) || (mem_reg_write && mem_hit);
`endif

    fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs_i(in_rs1), .ex_en_i(ex_fwd), .ex_rd_i(ex_rd_q), .ex_data_i(alu_result),
        .mem_en_i(mem_fwd), .mem_rd_i(mem_rd), .mem_data_i(mem_data),
        .wb_en_i(wb_reg_write), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .rf_data_i(in_rs1_data), .data_o(rs1_val)
    );
    fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs_i(in_rs2), .ex_en_i(ex_fwd), .ex_rd_i(ex_rd_q), .ex_data_i(alu_result),
        .mem_en_i(mem_fwd), .mem_rd_i(mem_rd), .mem_data_i(mem_data),
        .wb_en_i(wb_reg_write), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .rf_data_i(in_rs2_data), .data_o(rs2_val)
    );

    // flush beats stall, stall beats a pending capture or bubble
    assign in_ready = rst_n && (flush || (!ex_stall && !hazard));
    always_comb begin
        st = flush ? BUBBLE : ex_stall ? HOLD : (in_valid && !hazard) ? ADVANCE : BUBBLE;
        ex_valid_d     = (st == ADVANCE) || (st == HOLD && ex_valid_q);
        ex_reg_write_d = (st == ADVANCE) ? in_reg_write : (st == HOLD) && ex_reg_write_q;
        ex_mem_read_d  = (st == ADVANCE) ? in_mem_read  : (st == HOLD) && ex_mem_read_q;
        ex_a_d  = (st == ADVANCE) ? (in_use_pc ? in_pc : rs1_val)   : ex_a_q;
        ex_b_d  = (st == ADVANCE) ? (in_use_imm ? in_imm : rs2_val) : ex_b_q;
        ex_op_d = (st == ADVANCE) ? in_op : ex_op_q;
        ex_rd_d = (st == ADVANCE) ? in_rd : ex_rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_a_q         <= '0;
            ex_b_q         <= '0;
            ex_op_q        <= '0;
            ex_rd_q        <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_a_q         <= ex_a_d;
            ex_b_q         <= ex_b_d;
            ex_op_q        <= ex_op_d;
            ex_rd_q        <= ex_rd_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;
    assign ex_a         = ex_a_q;
    assign ex_b         = ex_b_q;
    assign ex_op        = ex_op_q;
    assign ex_rd        = ex_rd_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed scenarios plus random traffic against a behavioural model of the stage.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;
`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid, in_ready, in_use_imm, in_use_pc, in_reg_write, in_mem_read;
    logic [4:0]  in_rs1, in_rs2, in_rd, mem_rd, wb_rd, ex_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc, alu_result, mem_data, wb_data, ex_a, ex_b;
    logic [3:0]  in_op, ex_op;
    logic        mem_reg_write, wb_reg_write, ex_stall, flush, ex_valid, ex_reg_write, ex_mem_read;
    int          checks = 0, passes = 0, fails = 0;
    logic        m_valid, m_rw, m_mr, rdy_seen;
    logic [31:0] m_a, m_b, sa, sb;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;

    always #5 clk = ~clk;

    ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_pc(in_pc),
        .in_use_imm(in_use_imm), .in_use_pc(in_use_pc), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_op(in_op), .alu_result(alu_result),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_a(ex_a), .ex_b(ex_b), .ex_op(ex_op), .ex_rd(ex_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // newest pending writer of rs wins; x0 is hardwired zero
    function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] rf);
        logic [4:0]  rd[3];
        logic        en[3];
        logic [31:0] d[3];
        rd = '{m_rd, mem_rd, wb_rd};
        en = '{FWD && m_valid && m_rw && !m_mr, FWD && mem_reg_write, wb_reg_write};
        d  = '{alu_result, mem_data, wb_data};
        if (rs == 5'd0) return 32'd0;
        for (int i = 0; i < 3; i++) if (en[i] && rd[i] == rs) return d[i];
        return rf;
    endfunction

    function automatic logic reads(input logic [4:0] rd);
        return rd != 5'd0 && ((!in_use_pc && in_rs1 == rd) || (!in_use_imm && in_rs2 == rd));
    endfunction

    task automatic tick();
        logic blocked, exp_rdy;
        logic [31:0] na, nb;
        #1;
        blocked = (m_valid && m_mr && reads(m_rd)) ||
                  (!FWD && ((m_valid && m_rw && reads(m_rd)) || (mem_reg_write && reads(mem_rd))));
        exp_rdy = flush || !(ex_stall || blocked);
        rdy_seen = in_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        na = in_use_pc ? in_pc : resolve(in_rs1, in_rs1_data);
        nb = in_use_imm ? in_imm : resolve(in_rs2, in_rs2_data);
        if (flush) {m_valid, m_rw, m_mr} = 3'b000;
        else if (ex_stall) m_valid = m_valid;
        else if (in_valid && exp_rdy) begin
            {m_valid, m_rw, m_mr} = {1'b1, in_reg_write, in_mem_read};
            {m_a, m_b, m_op, m_rd} = {na, nb, in_op, in_rd};
        end else {m_valid, m_rw, m_mr} = 3'b000;
        @(posedge clk);
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m_rw));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m_mr));
        if (m_valid) begin
            chk("ex_a", ex_a, m_a);
            chk("ex_b", ex_b, m_b);
            chk("ex_op", 32'(ex_op), 32'(m_op));
            chk("ex_rd", 32'(ex_rd), 32'(m_rd));
        end
    endtask

    task automatic chk_reset();
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_rw", 32'(ex_reg_write), 32'd0);
        chk("rst_mr", 32'(ex_mem_read), 32'd0);
        chk("rst_a", ex_a, 32'd0);
        chk("rst_b", ex_b, 32'd0);
        chk("rst_op", 32'(ex_op), 32'd0);
        chk("rst_rd", 32'(ex_rd), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        {m_valid, m_rw, m_mr, m_a, m_b, m_op, m_rd} = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk_reset();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic ins(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic rw, input logic mr);
        {in_valid, in_rd, in_rs1, in_rs2, in_rs1_data, in_rs2_data} = {v, rd, rs1, rs2, d1, d2};
        {in_reg_write, in_mem_read, in_use_pc, in_use_imm} = {rw, mr, 2'b00};
        {in_op, in_imm, in_pc} = {ALU_ADD_OP, 64'd0};
    endtask

    initial begin
        ins(0, 0, 0, 0, 0, 0, 0, 0);
        {alu_result, mem_rd, mem_reg_write, mem_data, wb_rd, wb_reg_write, wb_data} = '0;
        {ex_stall, flush} = 2'b00;
        #2;
        chk_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // basic capture
        ins(1, 10, 1, 2, 5, 7, 1, 0);
        tick();
        chk("s1_a", ex_a, 32'd5);
        chk("s1_b", ex_b, 32'd7);
        chk("s1_valid", 32'(ex_valid), 32'd1);
        // back-to-back dependency
        ins(1, 3, 1, 2, 5, 7, 1, 0);
        tick();
        ins(1, 4, 3, 3, 0, 0, 1, 0);
        alu_result = 32'd12;
        tick();
`ifndef EX_FORWARD_EN
        chk("raw_stall", 32'(rdy_seen), 32'd0);
        {alu_result, mem_rd, mem_reg_write, mem_data} = {32'd0, 5'd3, 1'b1, 32'd12};
        tick();
        {mem_reg_write, wb_rd, wb_reg_write, wb_data} = {1'b0, 5'd3, 1'b1, 32'd12};
        tick();
`endif
        chk("raw_a", ex_a, 32'd12);
        chk("raw_b", ex_b, 32'd12);
        {mem_reg_write, wb_reg_write} = 2'b00;
        // load-use
        ins(1, 5, 0, 0, 0, 0, 1, 1);
        tick();
        ins(1, 7, 5, 0, 1, 2, 1, 0);
        tick();
        chk("lu_ready", 32'(rdy_seen), 32'd0);
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        {mem_rd, mem_reg_write, mem_data} = {5'd5, 1'b1, 32'hDEADBEEF};
        tick();
`ifndef EX_FORWARD_EN
        {mem_reg_write, wb_rd, wb_reg_write, wb_data} = {1'b0, 5'd5, 1'b1, 32'hDEADBEEF};
        tick();
`endif
        chk("lu_a", ex_a, 32'hDEADBEEF);
        chk("lu_valid", 32'(ex_valid), 32'd1);
        // MEM beats WB
        {mem_rd, mem_reg_write, mem_data, wb_rd, wb_reg_write, wb_data} = {5'd6, 1'b1, 32'h11, 5'd6, 1'b1, 32'h22};
        ins(1, 8, 6, 0, 32'h33, 0, 1, 0);
        tick();
`ifdef EX_FORWARD_EN
        chk("prio_a", ex_a, 32'h11);
`else
        mem_reg_write = 1'b0;
        tick();
        chk("prio_a", ex_a, 32'h22);
`endif
        // stall then flush
        {mem_reg_write, wb_reg_write} = 2'b00;
        ins(1, 9, 1, 2, 32'hA, 32'hB, 1, 0);
        tick();
        {sa, sb} = {ex_a, ex_b};
        ex_stall = 1'b1;
        ins(1, 11, 1, 2, 1, 2, 1, 0);
        repeat (3) begin
            tick();
            chk("stall_ready", 32'(rdy_seen), 32'd0);
            chk("stall_a", ex_a, sa);
            chk("stall_b", ex_b, sb);
        end
        flush = 1'b1;
        tick();
        chk("flush_ready", 32'(rdy_seen), 32'd1);
        chk("flush_valid", 32'(ex_valid), 32'd0);
        {flush, ex_stall} = 2'b00;
        // x0 ignores a WB write to x0
        {wb_rd, wb_reg_write, wb_data} = {5'd0, 1'b1, 32'h99};
        ins(1, 12, 0, 0, 32'h55, 0, 1, 0);
        tick();
        chk("x0_a", ex_a, 32'd0);
        wb_reg_write = 1'b0;
        // pc/imm operands do not count as uses of a pending load
        ins(1, 9, 0, 0, 0, 0, 1, 1);
        tick();
        ins(1, 13, 9, 9, 0, 0, 1, 0);
        {in_use_pc, in_use_imm, in_pc, in_imm} = {2'b11, 32'h1000, 32'h44};
        tick();
        chk("pcimm_ready", 32'(rdy_seen), 32'd1);
        chk("pcimm_a", ex_a, 32'h1000);
        chk("pcimm_b", ex_b, 32'h44);
        // reset while holding
        ex_stall = 1'b1;
        tick();
        do_reset();
        {ex_stall, in_valid} = 2'b00;
        tick();
        chk("post_rst_valid", 32'(ex_valid), 32'd0);
        // random traffic
        for (int n = 0; n < 400; n++) begin
            in_valid     = $urandom_range(0, 3) != 0;
            in_rs1       = 5'($urandom_range(0, 7));
            in_rs2       = 5'($urandom_range(0, 7));
            in_rd        = 5'($urandom_range(0, 7));
            in_rs1_data  = $urandom;
            in_rs2_data  = $urandom;
            in_imm       = $urandom;
            in_pc        = $urandom;
            in_use_pc    = $urandom_range(0, 5) == 0;
            in_use_imm   = $urandom_range(0, 2) == 0;
            in_reg_write = $urandom_range(0, 3) != 0;
            in_mem_read  = $urandom_range(0, 3) == 0;
            in_op        = 4'($urandom_range(0, 9));
            alu_result   = $urandom;
            mem_rd       = 5'($urandom_range(0, 7));
            mem_reg_write = $urandom_range(0, 1) == 1;
            mem_data     = $urandom;
            wb_rd        = 5'($urandom_range(0, 7));
            wb_reg_write = $urandom_range(0, 1) == 1;
            wb_data      = $urandom;
            ex_stall     = $urandom_range(0, 7) == 0;
            flush        = $urandom_range(0, 15) == 0;
            tick();
            if ($urandom_range(0, 49) == 0) do_reset();
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
